pc_gen: RTL and testbench

- Parametrised fetch-stage program counter for the pipelined datapath; successor to the single-cycle PC register.
- Adds pipeline stall hold, branch/jump redirect, and exception vectoring with EPC capture.
- Buffers a redirect that arrives while fetch is stalled and applies it when the stall releases.
- Sits at the head of IF; feeds instruction-memory address and the IF/ID PC+INC value.

---
 rtl/pc_gen.sv | 93 +++++++++
 tb/tb_pc_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-stage program counter: sequential advance, stall hold, branch/jump
// redirect (buffered while stalled), and exception vectoring with EPC capture.
module pc_gen #(
  parameter int unsigned         WIDTH        = 32,
  parameter logic [WIDTH-1:0]    RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0]    EXC_VECTOR   = 32'h8000_0180,
  parameter int unsigned         INC          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_valid,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus_inc,
  output logic             pc_valid,
  output logic             pend_valid,
  output logic [WIDTH-1:0] epc
);

  // IDLE: no buffered redirect. PENDING: pend_target holds a redirect that
  // arrived while fetch was stalled. pend_valid is a direct view of the state.
  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             pc_valid_q;
  logic [WIDTH-1:0] pc_seq;

  assign pc_seq = pc_q + INC_W;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_VECTOR;
      pend_target_q <= '0;
      epc_q         <= '0;
      pc_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      epc_q         <= epc_d;
      pc_valid_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    epc_d         = epc_q;

    if (exc_valid) begin
      // Exceptions win over stall and redirect, and drop any pending target.
      pc_d    = EXC_VECTOR;
      epc_d   = pc_q;
      state_d = IDLE;
    end else if (redirect_valid && !stall) begin
      pc_d    = redirect_target;
      state_d = IDLE;
    end else if (redirect_valid && stall) begin
      // Newest redirect overwrites an older buffered one.
      pend_target_d = redirect_target;
      state_d       = PENDING;
    end else if (!stall) begin
      case (state_q)
        PENDING: begin
          pc_d    = pend_target_q;
          state_d = IDLE;
        end
        default: begin
          pc_d = pc_seq;
        end
      endcase
    end
  end

  assign pc_out      = pc_q;
  assign pc_plus_inc = pc_seq;
  assign pc_valid    = pc_valid_q;
  assign pend_valid  = (state_q == PENDING);
  assign epc         = epc_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus random stimulus,
// checked against a cycle model through an expected-value queue.
module tb_pc_gen;

  localparam int W = 32;
  localparam logic [W-1:0] RV  = 32'h0000_0000;
  localparam logic [W-1:0] EXC = 32'h8000_0180;

  logic         clk;
  logic         reset;
  logic         stall;
  logic         redirect_valid;
  logic [W-1:0] redirect_target;
  logic         exc_valid;
  logic [W-1:0] pc_out;
  logic [W-1:0] pc_plus_inc;
  logic         pc_valid;
  logic         pend_valid;
  logic [W-1:0] epc;

  pc_gen #(
    .WIDTH(W), .RESET_VECTOR(RV), .EXC_VECTOR(EXC), .INC(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .exc_valid(exc_valid),
    .pc_out(pc_out),
    .pc_plus_inc(pc_plus_inc),
    .pc_valid(pc_valid),
    .pend_valid(pend_valid),
    .epc(epc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected entries: {pc, epc, pc_valid, pend_valid}
  logic [2*W+1:0] exp_q[$];

  // Cycle model state
  logic [W-1:0] m_pc   = RV;
  logic [W-1:0] m_tgt  = '0;
  logic [W-1:0] m_epc  = '0;
  logic         m_pend = 1'b0;
  logic         m_val  = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic model_edge(input logic r, input logic s, input logic rv,
                            input logic [W-1:0] rt, input logic e);
    if (r) begin
      m_pc = RV; m_val = 1'b0; m_pend = 1'b0; m_tgt = '0; m_epc = '0;
    end else begin
      m_val = 1'b1;
      if (e) begin
        m_epc = m_pc; m_pc = EXC; m_pend = 1'b0;
      end else if (rv && !s) begin
        m_pc = rt; m_pend = 1'b0;
      end else if (rv && s) begin
        m_pend = 1'b1; m_tgt = rt;
      end else if (!s && m_pend) begin
        m_pc = m_tgt; m_pend = 1'b0;
      end else if (!s) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // driver: apply one cycle of inputs, push expectation, compare after the edge
  task automatic step(input logic r, input logic s, input logic rv,
                      input logic [W-1:0] rt, input logic e);
    logic [2*W+1:0] ex;
    @(negedge clk);
    reset = r; stall = s; redirect_valid = rv; redirect_target = rt; exc_valid = e;
    model_edge(r, s, rv, rt, e);
    exp_q.push_back({m_pc, m_epc, m_val, m_pend});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      ex = exp_q.pop_front();
      check("pc_out", pc_out, ex[2*W+1:W+2]);
      check("epc", epc, ex[W+1:2]);
      check("pc_valid", {31'd0, pc_valid}, {31'd0, ex[1]});
      check("pend_valid", {31'd0, pend_valid}, {31'd0, ex[0]});
      check("pc_plus_inc", pc_plus_inc, ex[2*W+1:W+2] + 32'd4);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; exc_valid = 1'b0;

    // Reset 2 cycles, free-run 4: 0,0,4,8,C,10
    step(1, 0, 0, '0, 0);
    check("tp_rst_valid", {31'd0, pc_valid}, 32'd0);
    step(1, 0, 0, '0, 0);
    check("tp_rst_pc", pc_out, 32'h0);
    step(0, 0, 0, '0, 0);
    check("tp_first_free", pc_out, 32'h4);
    check("tp_first_valid", {31'd0, pc_valid}, 32'd1);
    step(0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    check("tp_run_10", pc_out, 32'h10);

    // Stall hold
    for (int i = 0; i < 3; i++) step(0, 1, 0, '0, 0);
    check("tp_stall_hold", pc_out, 32'h10);
    step(0, 0, 0, '0, 0);
    check("tp_stall_rel", pc_out, 32'h14);

    // Redirects while stalled, latest wins
    step(0, 1, 1, 32'h40, 0);
    step(0, 1, 1, 32'h80, 0);
    check("tp_pend_set", {31'd0, pend_valid}, 32'd1);
    check("tp_pend_hold_pc", pc_out, 32'h14);
    step(0, 0, 0, '0, 0);
    check("tp_pend_apply", pc_out, 32'h80);
    check("tp_pend_clr", {31'd0, pend_valid}, 32'd0);
    step(0, 0, 0, '0, 0);
    check("tp_after_pend", pc_out, 32'h84);

    // Exception beats stalled redirect
    step(0, 0, 1, 32'h20, 0);
    step(0, 0, 0, '0, 0);
    check("tp_at_24", pc_out, 32'h24);
    step(0, 1, 1, 32'h300, 1);
    check("tp_exc_pc", pc_out, 32'h8000_0180);
    check("tp_exc_epc", epc, 32'h24);
    check("tp_exc_pend", {31'd0, pend_valid}, 32'd0);

    // Reset clears pending redirect and epc
    step(0, 1, 1, 32'h200, 0);
    step(1, 0, 0, '0, 0);
    check("tp_rst_pend", {31'd0, pend_valid}, 32'd0);
    check("tp_rst_epc", epc, 32'h0);
    step(0, 0, 0, '0, 0);
    check("tp_no_200", pc_out, 32'h4);

    // Wrap-around
    step(0, 0, 1, 32'hFFFF_FFF8, 0);
    check("tp_wrap_a", pc_out, 32'hFFFF_FFF8);
    step(0, 0, 0, '0, 0);
    check("tp_wrap_b", pc_out, 32'hFFFF_FFFC);
    check("tp_wrap_inc", pc_plus_inc, 32'h0);
    step(0, 0, 0, '0, 0);
    check("tp_wrap_c", pc_out, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] t;
      t = $urandom();
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0), t, ($urandom_range(0, 19) == 0));
    end

    check("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
